// File: rtl/timer_counter.sv
// Timer counting stage: prescaler, 64-bit up-counter with half-word loads,
// debug halt handshake and wrap detection.
module timer_counter #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned DIV_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 timer_en,
    input  logic                 div_en,
    input  logic [3:0]           div_val,
    input  logic                 dbg_mode,
    input  logic                 halt_req,
    input  logic                 timer_en_h_l,
    input  logic                 tdr0_load,
    input  logic                 tdr1_load,
    input  logic [CNT_W/2-1:0]   tdr0_data,
    input  logic [CNT_W/2-1:0]   tdr1_data,
    output logic [CNT_W-1:0]     cnt_value,
    output logic                 halt_ack,
    output logic                 cnt_wrap
);

    localparam int unsigned HALF_W = CNT_W / 2;
    localparam int unsigned DV_W   = 4;

    logic [DV_W-1:0]    div_val_q;
    logic [DV_W-1:0]    div_eff;
    logic [DIV_MAX:0]   div_period;
    logic [DIV_MAX-1:0] div_term;
    logic [DIV_MAX-1:0] div_cnt;
    logic               active;
    logic               div_bypass;
    logic               div_changed;
    logic               div_done;
    logic               tick;
    logic               any_load;

    // Tick qualification: clamp the ratio, detect terminal count and config changes.
    always_comb begin
        div_eff     = (div_val > DV_W'(DIV_MAX)) ? DV_W'(DIV_MAX) : div_val;
        div_period  = (DIV_MAX+1)'(1) << div_eff;
        div_term    = div_period[DIV_MAX-1:0] - DIV_MAX'(1);
        active      = timer_en & ~halt_ack;
        div_bypass  = ~div_en | (div_val == DV_W'(0));
        div_changed = (div_val != div_val_q);
        div_done    = ~div_changed & (div_cnt == div_term);
        tick        = active & (div_bypass | div_done);
        any_load    = tdr0_load | tdr1_load;
    end

    // Halt handshake; acknowledged only in debug mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_ack <= 1'b0;
        end else begin
            halt_ack <= halt_req & dbg_mode;
        end
    end

    // Prescaler: restarts on disable or ratio change, keeps its phase while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            div_val_q <= '0;
        end else begin
            div_val_q <= div_val;
            if (!timer_en || !div_en || div_changed) begin
                div_cnt <= '0;
            end else if (halt_ack) begin
                div_cnt <= div_cnt;
            end else if (div_cnt == div_term) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_MAX'(1);
            end
        end
    end

    // Counter: clear beats load, load beats tick (coincident tick is dropped).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_value <= '0;
        end else if (timer_en_h_l) begin
            cnt_value <= '0;
        end else if (any_load) begin
            if (tdr0_load) begin
                cnt_value[HALF_W-1:0] <= tdr0_data;
            end
            if (tdr1_load) begin
                cnt_value[CNT_W-1:HALF_W] <= tdr1_data;
            end
        end else if (tick) begin
            cnt_value <= cnt_value + CNT_W'(1);
        end
    end

    // Wrap pulse only for an actual increment out of all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_wrap <= 1'b0;
        end else begin
            cnt_wrap <= tick & ~timer_en_h_l & ~any_load & (&cnt_value);
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: cycle scoreboard plus directed expectations.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        dbg_mode;
    logic        halt_req;
    logic        timer_en_h_l;
    logic        tdr0_load;
    logic        tdr1_load;
    logic [31:0] tdr0_data;
    logic [31:0] tdr1_data;
    logic [63:0] cnt_value;
    logic        halt_ack;
    logic        cnt_wrap;

    typedef struct packed {
        logic [63:0] cnt;
        logic        halt;
        logic        wrap;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [63:0] m_cnt  = '0;
    logic        m_halt = 1'b0;
    logic        m_wrap = 1'b0;
    int          m_div  = 0;
    logic [3:0]  m_dvq  = '0;

    timer_counter #(.CNT_W(64), .DIV_MAX(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .timer_en     (timer_en),
        .div_en       (div_en),
        .div_val      (div_val),
        .dbg_mode     (dbg_mode),
        .halt_req     (halt_req),
        .timer_en_h_l (timer_en_h_l),
        .tdr0_load    (tdr0_load),
        .tdr1_load    (tdr1_load),
        .tdr0_data    (tdr0_data),
        .tdr1_data    (tdr1_data),
        .cnt_value    (cnt_value),
        .halt_ack     (halt_ack),
        .cnt_wrap     (cnt_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance the reference by one clock from the currently driven inputs.
    task automatic model_update();
        int   eff;
        int   per;
        logic act;
        logic chg;
        logic byp;
        logic tk;
        logic ld;
        if (rst) begin
            m_cnt  = '0;
            m_halt = 1'b0;
            m_wrap = 1'b0;
            m_div  = 0;
            m_dvq  = '0;
        end else begin
            eff = (div_val > 4'd8) ? 8 : int'(div_val);
            per = 1 << eff;
            act = timer_en && !m_halt;
            chg = (div_val != m_dvq);
            byp = !div_en || (div_val == 4'd0);
            tk  = act && (byp || (!chg && m_div == per - 1));
            ld  = tdr0_load || tdr1_load;
            m_wrap = tk && !timer_en_h_l && !ld && (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
            if (timer_en_h_l) begin
                m_cnt = '0;
            end else if (ld) begin
                if (tdr0_load) m_cnt[31:0]  = tdr0_data;
                if (tdr1_load) m_cnt[63:32] = tdr1_data;
            end else if (tk) begin
                m_cnt = m_cnt + 64'd1;
            end
            if (!timer_en || !div_en || chg) m_div = 0;
            else if (m_halt) m_div = m_div;
            else if (m_div == per - 1) m_div = 0;
            else m_div = m_div + 1;
            m_halt = halt_req && dbg_mode;
            m_dvq  = div_val;
        end
    endtask

    // Drive one cycle: push the expectation, clock, then pop and compare.
    task automatic step();
        exp_t e;
        model_update();
        e.cnt  = m_cnt;
        e.halt = m_halt;
        e.wrap = m_wrap;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_cnt",  cnt_value,      e.cnt);
            check("sb_halt", 64'(halt_ack),  64'(e.halt));
            check("sb_wrap", 64'(cnt_wrap),  64'(e.wrap));
        end
    endtask

    initial begin
        rst = 1'b1; timer_en = 1'b1; div_en = 1'b0; div_val = 4'd0;
        dbg_mode = 1'b0; halt_req = 1'b0; timer_en_h_l = 1'b0;
        tdr0_load = 1'b0; tdr1_load = 1'b0; tdr0_data = '0; tdr1_data = '0;

        // Reset
        repeat (2) step();
        check("rst_cnt",  cnt_value, 64'd0);
        check("rst_halt", 64'(halt_ack), 64'd0);
        check("rst_wrap", 64'(cnt_wrap), 64'd0);
        rst = 1'b0;
        step(); check("run_1", cnt_value, 64'd1);
        step(); check("run_2", cnt_value, 64'd2);
        step(); check("run_3", cnt_value, 64'd3);

        // Prescaler /4, then change to /8 mid-count
        div_en = 1'b1; div_val = 4'd2;
        step();
        repeat (3) step();
        check("div4_hold", cnt_value, 64'd3);
        step();
        check("div4_tick1", cnt_value, 64'd4);
        repeat (4) step();
        check("div4_tick2", cnt_value, 64'd5);
        repeat (2) step();
        div_val = 4'd3;
        step();
        repeat (7) step();
        check("div8_hold", cnt_value, 64'd5);
        step();
        check("div8_tick", cnt_value, 64'd6);

        // Load vs tick
        div_en = 1'b0;
        tdr0_load = 1'b1; tdr0_data = 32'h0000_0010;
        step();
        tdr0_load = 1'b0;
        check("ld0_no_inc", cnt_value, 64'h10);
        step();
        check("ld0_resume", cnt_value, 64'h11);
        tdr1_load = 1'b1; tdr1_data = 32'hDEAD_BEEF;
        step();
        tdr1_load = 1'b0;
        check("ld1_high", cnt_value, 64'hDEAD_BEEF_0000_0011);
        step();
        check("ld1_low_counts", cnt_value, 64'hDEAD_BEEF_0000_0012);

        // Wrap
        tdr0_load = 1'b1; tdr1_load = 1'b1;
        tdr0_data = 32'hFFFF_FFFF; tdr1_data = 32'hFFFF_FFFF;
        step();
        tdr0_load = 1'b0; tdr1_load = 1'b0;
        check("wrap_ld_val", cnt_value, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_ld_nopulse", 64'(cnt_wrap), 64'd0);
        step();
        check("wrap_zero", cnt_value, 64'd0);
        check("wrap_pulse", 64'(cnt_wrap), 64'd1);
        step();
        check("wrap_one_cycle", 64'(cnt_wrap), 64'd0);
        timer_en = 1'b0;
        tdr0_load = 1'b1; tdr1_load = 1'b1;
        step();
        tdr0_load = 1'b0; tdr1_load = 1'b0;
        repeat (2) step();
        check("dis_hold", cnt_value, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dis_nowrap", 64'(cnt_wrap), 64'd0);

        // Halt handshake
        timer_en = 1'b1;
        tdr0_load = 1'b1; tdr1_load = 1'b1; tdr0_data = 32'h100; tdr1_data = '0;
        step();
        tdr0_load = 1'b0; tdr1_load = 1'b0;
        check("halt_ld", cnt_value, 64'h100);
        dbg_mode = 1'b1; halt_req = 1'b1;
        step();
        check("halt_ack_set", 64'(halt_ack), 64'd1);
        check("halt_last_inc", cnt_value, 64'h101);
        repeat (3) step();
        check("halt_frozen", cnt_value, 64'h101);
        halt_req = 1'b0;
        step();
        check("halt_ack_clr", 64'(halt_ack), 64'd0);
        check("halt_still", cnt_value, 64'h101);
        step();
        check("halt_resume", cnt_value, 64'h102);
        dbg_mode = 1'b0; halt_req = 1'b1;
        repeat (3) step();
        check("halt_nodbg_ack", 64'(halt_ack), 64'd0);
        check("halt_nodbg_cnt", cnt_value, 64'h105);
        halt_req = 1'b0;

        // Disable clear beats load
        tdr0_load = 1'b1; tdr1_load = 1'b1; tdr0_data = 32'h55; tdr1_data = '0;
        step();
        tdr1_load = 1'b0;
        check("clr_ld", cnt_value, 64'h55);
        timer_en = 1'b0; timer_en_h_l = 1'b1; tdr0_data = 32'h77;
        step();
        timer_en_h_l = 1'b0; tdr0_load = 1'b0;
        check("clr_zero", cnt_value, 64'd0);
        timer_en = 1'b1;

        // Randomised traffic against the reference
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) timer_en = ~timer_en;
            timer_en_h_l = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) div_en = ~div_en;
            if ($urandom_range(0, 29) == 0) div_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) dbg_mode = ~dbg_mode;
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            tdr0_load = ($urandom_range(0, 24) == 0);
            tdr1_load = ($urandom_range(0, 24) == 0);
            tdr0_data = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            tdr1_data = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
